// File: rtl/bus_pkg.sv
// Shared bus definitions: master-port state encoding, default widths,
// slave-select field location and read/write direction encoding.
package bus_pkg;

   localparam int BUS_ADDR_WIDTH = 14;
   localparam int BUS_DATA_WIDTH = 8;

   // Top two address bits select the slave; the rest is the in-slave offset.
   localparam int SSEL_MSB = BUS_ADDR_WIDTH - 1;
   localparam int SSEL_LSB = BUS_ADDR_WIDTH - 2;

   localparam logic BUS_READ  = 1'b0;
   localparam logic BUS_WRITE = 1'b1;

   typedef enum logic [2:0] {
      MP_IDLE,
      MP_REQ,
      MP_ADDR,
      MP_WDATA,
      MP_WAIT_DONE,
      MP_RDATA,
      MP_SPLIT_WAIT,
      MP_COMPLETE
   } mp_state_e;

   function automatic int bus_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// Parallel-load shift register: shifts right each enabled cycle, so the
// LSB leaves first on sout_o and sin_i enters at the MSB.
module bus_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_data_i,
   input  logic             shift_i,
   input  logic             sin_i,
   output logic [WIDTH-1:0] data_o,
   output logic             sout_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // Load wins over shift so a reload always restarts from bit 0.
   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = load_data_i;
      end else if (shift_i) begin
         data_d = {sin_i, data_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;
   assign sout_o = data_q[0];

endmodule

// File: rtl/bus_master_port.sv
// Master-side serial bus port: requests the bus for one local command,
// serialises address/write data, gathers read data, and handles split/timeout.
module bus_master_port
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
   parameter int DATA_WIDTH = BUS_DATA_WIDTH,
   parameter int TIMEOUT    = 1023
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  M_EXECUTE,
   input  logic                  M_RW,
   input  logic [ADDR_WIDTH-1:0] M_ADDR,
   input  logic [DATA_WIDTH-1:0] M_WDATA,
   output logic                  M_BUSY,
   output logic                  M_DONE,
   output logic                  M_ERROR,
   output logic [DATA_WIDTH-1:0] M_RDATA,
   output logic                  B_REQ,
   input  logic                  B_GRANT,
   output logic                  B_UTIL,
   output logic                  B_RW,
   output logic                  B_MDATA,
   output logic                  B_MVALID,
   input  logic                  B_SDATA,
   input  logic                  B_SVALID,
   input  logic                  B_SPLIT,
   input  logic                  B_SPL_RESUME,
   input  logic                  B_DONE
);

   localparam int CNT_W = $clog2(bus_max(ADDR_WIDTH, DATA_WIDTH));
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int TX_W  = ADDR_WIDTH + DATA_WIDTH;

   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

   mp_state_e state_q, state_d;
   mp_state_e ret_q, ret_d;

   logic                  rw_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  cmd_load;

   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             rx_full_q, rx_full_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             tmo_hit;

   logic            tx_load, tx_shift, tx_sout;
   logic [TX_W-1:0] tx_load_data;
   logic [TX_W-1:0] unused_tx_data;

   logic                  rx_shift, rx_last;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  unused_rx_sout;

   logic [DATA_WIDTH-1:0] m_rdata_q, m_rdata_d;
   logic m_busy_q, m_busy_d;
   logic m_done_q, m_done_d;
   logic m_error_q, m_error_d;
   logic b_req_q, b_req_d;
   logic b_util_q, b_util_d;
   logic b_rw_q, b_rw_d;
   logic b_mvalid_q, b_mvalid_d;

   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
   // A bit arriving this cycle restarts the idle window, so it cannot time out.
   assign tmo_hit = (tmo_q == TMO_LAST) && !((state_q == MP_RDATA) && B_SVALID);

   always_comb begin
      state_d   = state_q;
      ret_d     = ret_q;
      cnt_d     = cnt_q;
      rx_full_d = rx_full_q;
      m_rdata_d = m_rdata_q;
      m_error_d = 1'b0;
      cmd_load  = 1'b0;
      rx_shift  = 1'b0;
      rx_last   = 1'b0;
      unique case (state_q)
         MP_IDLE: begin
            if (M_EXECUTE) begin
               cmd_load = 1'b1;
               state_d  = MP_REQ;
            end
         end
         MP_REQ: begin
            if (B_GRANT) begin
               cnt_d   = '0;
               state_d = MP_ADDR;
            end
         end
         MP_ADDR: begin
            if (!B_GRANT && !B_SPLIT) begin
               state_d = MP_REQ;
            end else if (cnt_q == ADDR_LAST) begin
               cnt_d     = '0;
               rx_full_d = 1'b0;
               state_d   = (rw_q == BUS_WRITE) ? MP_WDATA : MP_RDATA;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         MP_WDATA: begin
            if (!B_GRANT && !B_SPLIT) begin
               state_d = MP_REQ;
            end else if (cnt_q == DATA_LAST) begin
               cnt_d   = '0;
               state_d = MP_WAIT_DONE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         MP_WAIT_DONE: begin
            if (B_DONE) begin
               state_d = MP_COMPLETE;
            end else if (B_SPLIT) begin
               ret_d   = MP_WAIT_DONE;
               state_d = MP_SPLIT_WAIT;
            end else if (tmo_hit) begin
               m_error_d = 1'b1;
               state_d   = MP_COMPLETE;
            end
         end
         MP_RDATA: begin
            rx_shift = B_SVALID && !rx_full_q;
            rx_last  = rx_shift && (cnt_q == DATA_LAST);
            if (rx_shift) begin
               cnt_d = cnt_inc;
            end
            if (rx_last) begin
               rx_full_d = 1'b1;
            end
            if ((rx_full_q || rx_last) && B_DONE) begin
               // The final bit is still in flight into rx_data, so splice it in here.
               m_rdata_d = rx_last ? {B_SDATA, rx_data[DATA_WIDTH-1:1]} : rx_data;
               state_d   = MP_COMPLETE;
            end else if (B_SPLIT) begin
               ret_d     = MP_RDATA;
               cnt_d     = '0;
               rx_full_d = 1'b0;
               state_d   = MP_SPLIT_WAIT;
            end else if (tmo_hit) begin
               m_error_d = 1'b1;
               state_d   = MP_COMPLETE;
            end
         end
         MP_SPLIT_WAIT: begin
            if (B_SPL_RESUME && B_GRANT) begin
               cnt_d     = '0;
               rx_full_d = 1'b0;
               state_d   = ret_q;
            end else if (tmo_hit) begin
               m_error_d = 1'b1;
               state_d   = MP_COMPLETE;
            end
         end
         MP_COMPLETE: begin
            state_d = MP_IDLE;
         end
         default: begin
            state_d = MP_IDLE;
         end
      endcase
   end

   always_comb begin
      tmo_d = '0;
      if ((state_d == state_q)
          && (state_q inside {MP_WAIT_DONE, MP_RDATA, MP_SPLIT_WAIT})
          && !((state_q == MP_RDATA) && B_SVALID)) begin
         tmo_d = tmo_q + TMO_W'(1);
      end
   end

   // Bus outputs are decoded from the next state so they are flop outputs
   // that line up with the state they describe.
   always_comb begin
      b_mvalid_d   = (state_d == MP_ADDR) || (state_d == MP_WDATA);
      b_rw_d       = b_mvalid_d && rw_q;
      b_util_d     = state_d inside {MP_ADDR, MP_WDATA, MP_WAIT_DONE, MP_RDATA};
      b_req_d      = state_d inside {MP_REQ, MP_ADDR, MP_WDATA, MP_WAIT_DONE,
                                     MP_RDATA, MP_SPLIT_WAIT};
      m_busy_d     = (state_d != MP_IDLE);
      m_done_d     = (state_d == MP_COMPLETE);
      tx_load      = (state_q == MP_REQ) || !b_mvalid_d;
      tx_load_data = b_mvalid_d ? {wdata_q, addr_q} : '0;
      tx_shift     = (state_q inside {MP_ADDR, MP_WDATA}) && b_mvalid_d;
   end

   bus_shift_reg #(
      .WIDTH (TX_W)
   ) u_tx (
      .clk_i       (CLK),
      .rst_n_i     (RSTN),
      .load_i      (tx_load),
      .load_data_i (tx_load_data),
      .shift_i     (tx_shift),
      .sin_i       (1'b0),
      .data_o      (unused_tx_data),
      .sout_o      (tx_sout)
   );

   // Held clear outside RDATA, which also drops partial bits on a split.
   bus_shift_reg #(
      .WIDTH (DATA_WIDTH)
   ) u_rx (
      .clk_i       (CLK),
      .rst_n_i     (RSTN),
      .load_i      (state_q != MP_RDATA),
      .load_data_i ('0),
      .shift_i     (rx_shift),
      .sin_i       (B_SDATA),
      .data_o      (rx_data),
      .sout_o      (unused_rx_sout)
   );

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q    <= MP_IDLE;
         ret_q      <= MP_IDLE;
         rw_q       <= BUS_READ;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         rx_full_q  <= 1'b0;
         tmo_q      <= '0;
         m_rdata_q  <= '0;
         m_busy_q   <= 1'b0;
         m_done_q   <= 1'b0;
         m_error_q  <= 1'b0;
         b_req_q    <= 1'b0;
         b_util_q   <= 1'b0;
         b_rw_q     <= 1'b0;
         b_mvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ret_q      <= ret_d;
         cnt_q      <= cnt_d;
         rx_full_q  <= rx_full_d;
         tmo_q      <= tmo_d;
         m_rdata_q  <= m_rdata_d;
         m_busy_q   <= m_busy_d;
         m_done_q   <= m_done_d;
         m_error_q  <= m_error_d;
         b_req_q    <= b_req_d;
         b_util_q   <= b_util_d;
         b_rw_q     <= b_rw_d;
         b_mvalid_q <= b_mvalid_d;
         if (cmd_load) begin
            rw_q    <= M_RW;
            addr_q  <= M_ADDR;
            wdata_q <= M_WDATA;
         end
      end
   end

   assign M_BUSY   = m_busy_q;
   assign M_DONE   = m_done_q;
   assign M_ERROR  = m_error_q;
   assign M_RDATA  = m_rdata_q;
   assign B_REQ    = b_req_q;
   assign B_UTIL   = b_util_q;
   assign B_RW     = b_rw_q;
   assign B_MDATA  = tx_sout;
   assign B_MVALID = b_mvalid_q;

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side bus interface that sits directly upstream of the bus arbiter.
- Accepts one read or write command from a local master and raises that master's request line. On grant it asserts utilisation and shifts the address and write data out serially.
- For reads, it collects serial read data from the slave.
- Honours split release and resume, then reports completion and read data back to the local master.

Parameters:
- ADDR_WIDTH, 14, serial address bits (2 slave-select MSBs + 12 offset)
- DATA_WIDTH, 8, data word bits
- TIMEOUT, 1023, max cycles waiting for B_DONE or read data before error completion

Ports:
- CLK  input  1  bus clock
- RSTN  input  1  async active-low reset
- M_EXECUTE  input  1  start command; sampled in IDLE only
- M_RW  input  1  1=write, 0=read; latched with M_EXECUTE
- M_ADDR  input  ADDR_WIDTH  target address; latched
- M_WDATA  input  DATA_WIDTH  write data; latched
- M_BUSY  output  1  command in progress (state != IDLE)
- M_DONE  output  1  one-cycle completion pulse
- M_ERROR  output  1  valid with M_DONE; 1 = timeout
- M_RDATA  output  DATA_WIDTH  read result; updated on successful read completion, held otherwise
- B_REQ  output  1  this master's arbiter request line
- B_GRANT  input  1  this master's grant bit from arbiter
- B_UTIL  output  1  bus in use by this master
- B_RW  output  1  direction, driven during ADDR/WDATA
- B_MDATA  output  1  serial master-to-slave bit
- B_MVALID  output  1  B_MDATA valid
- B_SDATA  input  1  serial slave-to-master bit
- B_SVALID  input  1  B_SDATA valid
- B_SPLIT  input  1  slave requested split
- B_SPL_RESUME  input  1  arbiter resuming split transaction
- B_DONE  input  1  slave transaction complete

Behaviour:
- Reset: state IDLE; all outputs 0; M_RDATA 0; counters 0. Reset mid-transaction aborts immediately with no M_DONE pulse.
- Timing: all outputs are registered; transitions occur on posedge CLK.
- States: IDLE, REQ, ADDR, WDATA, WAIT_DONE, RDATA, SPLIT_WAIT, COMPLETE.
- IDLE:
  - M_EXECUTE=1 latches RW, ADDR and WDATA, sets B_REQ=1 and goes to REQ.
  - M_EXECUTE is ignored in every other state.
- REQ:
  - B_REQ held at 1.
  - B_GRANT=1 sets B_UTIL=1, clears the bit counter and goes to ADDR.
- ADDR:
  - Drive B_MVALID=1, B_RW=latched RW, B_MDATA=addr[bit], LSB first, one bit per cycle.
  - Needs ADDR_WIDTH cycles. After bit ADDR_WIDTH-1, write goes to WDATA and read goes to RDATA.
- WDATA:
  - Shift out DATA_WIDTH bits LSB first with B_MVALID=1, then go to WAIT_DONE.
  - B_MVALID=0 outside ADDR and WDATA.
- WAIT_DONE:
  - B_DONE=1 goes to COMPLETE.
  - B_SPLIT=1 goes to SPLIT_WAIT.
- RDATA:
  - On each B_SVALID=1, shift B_SDATA into the read register at the bit-counter position.
  - Once DATA_WIDTH bits are received and B_DONE=1 (same cycle as the last bit or later), copy to M_RDATA and go to COMPLETE.
  - B_SPLIT=1 before completion goes to SPLIT_WAIT and discards any partial bits.
- SPLIT_WAIT:
  - B_UTIL=0; B_REQ remains 1.
  - B_SPL_RESUME=1 and B_GRANT=1 set B_UTIL=1, reset the bit counter and return to the pre-split state (RDATA or WAIT_DONE). The address is not resent.
- Grant loss:
  - B_GRANT=0 in ADDR or WDATA without B_SPLIT means arbitration was lost.
  - Response: B_UTIL=0, back to REQ, restart from address bit 0.
- Timeout:
  - A counter runs in WAIT_DONE, RDATA and SPLIT_WAIT and clears on any B_SVALID or state change.
  - Reaching TIMEOUT goes to COMPLETE with M_ERROR=1.
- COMPLETE:
  - One cycle: M_DONE=1, B_REQ=0, B_UTIL=0, then IDLE.
  - A new M_EXECUTE is accepted from the following IDLE cycle.
- Priority:
  - Same cycle: B_DONE > B_SPLIT > timeout.
  - B_SPL_RESUME outside SPLIT_WAIT is ignored.
  - B_SVALID outside RDATA is ignored.
- Width rules:
  - Bit counter is $clog2(max(ADDR_WIDTH,DATA_WIDTH)) bits and saturates; no wrap.
  - Timeout counter is $clog2(TIMEOUT+1) bits.

Decomposition:
- Shared package bus_pkg holds:
  - master-port state enum typedef
  - ADDR_WIDTH/DATA_WIDTH defaults
  - slave-select field position constants
  - RW encoding constants (BUS_READ=0, BUS_WRITE=1)
- Sub-module bus_shift_reg:
  - Parameterised WIDTH; parallel load, serial shift-out LSB first, serial shift-in with valid.
  - Two instances: TX (addr/wdata) and RX (rdata).

Test Plan:
- Write, addr=14'h1A5C, data=8'hC3, grant after 3 cycles:
  - B_MDATA shows LSB-first 14 addr bits then 8 data bits with B_RW=1.
  - B_DONE then gives M_DONE=1, M_ERROR=0 and B_REQ=0 the next cycle.
- Read, addr=14'h0010, slave returns 8'h5A serially with B_DONE on the last bit:
  - M_RDATA=8'h5A and M_DONE pulses once.
- Read split: B_SPLIT after 2 data bits, then B_SPL_RESUME+B_GRANT 20 cycles later with 8'hA7 resent:
  - B_UTIL=0 and B_REQ=1 during the wait; M_RDATA=8'hA7.
- Grant dropped at address bit 5 without split:
  - Returns to REQ; on re-grant the address restarts at bit 0.
- No B_DONE after write with TIMEOUT=15:
  - M_DONE with M_ERROR=1 exactly 15 cycles into WAIT_DONE.
  - M_RDATA unchanged.
- RSTN low during RDATA:
  - All outputs 0 asynchronously, no M_DONE.
  - A new M_EXECUTE after release works normally.
